// File: rtl/branch_demux_pkg.sv
// Shared types for the branch demultiplexer: destination tags, branch count
// and the flush state machine encoding.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_A   = 2'd0,
    BR_B   = 2'd1,
    BR_C   = 2'd2,
    BR_INV = 2'd3
  } branch_e;

  localparam int NUM_BR = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/branch_demux_fifo.sv
// Per-branch FIFO buffer with wrap-around pointers; the extra pointer bit
// tells a full buffer apart from an empty one.
module branch_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: contents are only visible while the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/branch_demux.sv
// Routes each input word to one of three branch FIFOs by its destination tag,
// with a flush sequence that stops intake until every branch has drained.
module branch_demux
  import branch_pkg::*;
#(
  parameter int DW         = 8,
  parameter int DEPTH      = 2,
  parameter int DEFAULT_BR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [1:0]           in_dest,
  output logic [NUM_BR-1:0]    out_valid,
  input  logic [NUM_BR-1:0]    out_ready,
  output logic [NUM_BR*DW-1:0] out_data,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [7:0]           inv_cnt
);

  localparam logic [1:0] DEF_BR = 2'(DEFAULT_BR);

  state_e            state;
  state_e            state_next;
  logic [1:0]        eff;
  logic              eff_full;
  logic              accept;
  logic [NUM_BR-1:0] push_br;
  logic [NUM_BR-1:0] pop_br;
  logic [NUM_BR-1:0] full_br;
  logic [NUM_BR-1:0] empty_br;

  assign eff = (in_dest == BR_INV) ? DEF_BR : in_dest;

  always_comb begin
    eff_full = 1'b1;
    case (eff)
      BR_A:    eff_full = full_br[0];
      BR_B:    eff_full = full_br[1];
      BR_C:    eff_full = full_br[2];
      default: eff_full = 1'b1;
    endcase
  end

  assign in_ready = (state == RUN) && !eff_full;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NUM_BR; i++) begin : g_branch
    assign push_br[i] = accept && (eff == 2'(i));
    assign pop_br[i]  = !empty_br[i] && out_ready[i];

    branch_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_br[i]),
      .pop   (pop_br[i]),
      .din   (in_data),
      .full  (full_br[i]),
      .empty (empty_br[i]),
      .head  (out_data[i*DW +: DW])
    );
  end

  assign out_valid  = ~empty_br;
  assign flush_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_req) state_next = DRAIN;
      DRAIN:   if (&empty_br) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt <= '0;
    end else if (accept && (in_dest == BR_INV) && (inv_cnt != 8'hFF)) begin
      inv_cnt <= inv_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_branch_demux.sv
// Randomised and directed bench for branch_demux, checked every cycle against
// a queue-based reference model of the routing, flush and counting rules.
module tb_branch_demux;

  localparam int DW         = 8;
  localparam int DEPTH      = 2;
  localparam int DEFAULT_BR = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [1:0]      in_dest = '0;
  logic [2:0]      out_valid;
  logic [2:0]      out_ready = '0;
  logic [3*DW-1:0] out_data;
  logic            flush_req = 1'b0;
  logic            flush_done;
  logic [7:0]      inv_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] q_c[$];
  int            m_phase = 0;
  int            m_inv   = 0;

  branch_demux #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .DEFAULT_BR (DEFAULT_BR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .inv_cnt    (inv_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qhead(input int i);
    case (i)
      0:       return q_a[0];
      1:       return q_b[0];
      default: return q_c[0];
    endcase
  endfunction

  function automatic int eff_of(input logic [1:0] d);
    return (d == 2'd3) ? DEFAULT_BR : int'(d);
  endfunction

  function automatic logic exp_ready();
    return (m_phase == 0) && (qsize(eff_of(in_dest)) < DEPTH);
  endfunction

  // Reference model: phase 0 = accepting, 1 = draining, 2 = drain complete.
  always @(posedge clk or negedge rst_n) begin : model
    logic acc;
    logic all_empty;
    int   e;
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      q_c.delete();
      m_phase = 0;
      m_inv   = 0;
    end else begin
      acc       = in_valid && exp_ready();
      e         = eff_of(in_dest);
      all_empty = (q_a.size() == 0) && (q_b.size() == 0) && (q_c.size() == 0);
      if (out_ready[0] && q_a.size() > 0) void'(q_a.pop_front());
      if (out_ready[1] && q_b.size() > 0) void'(q_b.pop_front());
      if (out_ready[2] && q_c.size() > 0) void'(q_c.pop_front());
      if (acc) begin
        case (e)
          0:       q_a.push_back(in_data);
          1:       q_b.push_back(in_data);
          default: q_c.push_back(in_data);
        endcase
        if (in_dest == 2'd3 && m_inv < 255) m_inv++;
      end
      case (m_phase)
        0:       if (flush_req) m_phase = 1;
        1:       if (all_empty) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, exp_ready());
    for (int i = 0; i < 3; i++) begin
      check($sformatf("out_valid[%0d]", i), out_valid[i], qsize(i) > 0);
      if (qsize(i) > 0)
        check($sformatf("out_data[%0d]", i), out_data[i*DW +: DW], qhead(i));
    end
    check("flush_done", flush_done, m_phase == 2);
    check("inv_cnt", inv_cnt, m_inv);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic [1:0] dst);
    in_valid = v;
    in_data  = d;
    in_dest  = dst;
  endtask

  initial begin
    int pulses;

    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset inv_cnt", inv_cnt, 0);

    // One word per branch with every consumer ready.
    out_ready = 3'b111;
    apply_stimulus(1, 8'h11, 2'd0);
    tick();
    check("s37 valid A", out_valid, 3'b001);
    check("s37 data A", out_data[7:0], 8'h11);
    apply_stimulus(1, 8'h22, 2'd1);
    tick();
    check("s37 valid B", out_valid, 3'b010);
    check("s37 data B", out_data[15:8], 8'h22);
    apply_stimulus(1, 8'h33, 2'd2);
    tick();
    check("s37 valid C", out_valid, 3'b100);
    check("s37 data C", out_data[23:16], 8'h33);
    apply_stimulus(0, 8'h00, 2'd0);
    tick();

    // Back-pressure on branch A blocks only A-bound words.
    out_ready = 3'b110;
    apply_stimulus(1, 8'hA1, 2'd0);
    tick();
    apply_stimulus(1, 8'hA2, 2'd0);
    tick();
    apply_stimulus(1, 8'hA3, 2'd0);
    #1;
    check("s38 A full", in_ready, 0);
    tick();
    apply_stimulus(1, 8'hB1, 2'd1);
    #1;
    check("s38 B open", in_ready, 1);
    tick();
    apply_stimulus(1, 8'hA3, 2'd0);
    out_ready = 3'b111;
    tick();
    out_ready = 3'b110;
    #1;
    check("s38 A freed", in_ready, 1);
    tick();
    apply_stimulus(0, 8'h00, 2'd0);
    out_ready = 3'b111;
    repeat (4) tick();

    // Invalid destinations go to the default branch and are counted.
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1, 8'(8'h50 + k), 2'd3);
      tick();
    end
    apply_stimulus(0, 8'h00, 2'd0);
    tick();
    check("s39 inv_cnt 5", inv_cnt, 5);
    for (int k = 0; k < 260; k++) begin
      apply_stimulus(1, 8'($urandom), 2'd3);
      tick();
    end
    apply_stimulus(0, 8'h00, 2'd0);
    tick();
    check("s39 inv_cnt sat", inv_cnt, 255);

    // Flush with A and B full; consumers released after four cycles.
    out_ready = 3'b000;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 8'(8'hC0 + k), 2'(k / 2));
      tick();
    end
    apply_stimulus(0, 8'h00, 2'd0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    pulses = 0;
    apply_stimulus(1, 8'h77, 2'd2);
    for (int k = 0; k < 4; k++) begin
      check("s40 drain in_ready", in_ready, 0);
      tick();
      if (flush_done) pulses++;
    end
    apply_stimulus(0, 8'h00, 2'd0);
    out_ready = 3'b111;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (flush_done) pulses++;
    end
    check("s40 flush pulses", pulses, 1);

    // Flush while already empty: done two cycles after the request.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("empty flush early", flush_done, 0);
    tick();
    check("empty flush done", flush_done, 1);
    tick();

    // Reset mid-stream with A full.
    out_ready = 3'b000;
    apply_stimulus(1, 8'hD1, 2'd0);
    tick();
    apply_stimulus(1, 8'hD2, 2'd0);
    tick();
    apply_stimulus(0, 8'h00, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("s41 reset out_valid", out_valid, 0);
    check("s41 reset inv_cnt", inv_cnt, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("s41 release in_ready", in_ready, 1);
    out_ready = 3'b111;
    repeat (3) tick();
    check("s41 no stale", out_valid, 0);

    // Simultaneous push and pop on B at occupancy 1.
    out_ready = 3'b000;
    apply_stimulus(1, 8'hE0, 2'd1);
    tick();
    out_ready = 3'b010;
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(1, 8'(8'hE0 + k), 2'd1);
      tick();
    end
    check("s42 B occupied", out_valid[1], 1);
    apply_stimulus(0, 8'h00, 2'd0);
    tick();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)));
      out_ready = 3'($urandom);
      flush_req = ($urandom_range(0, 49) == 0);
      tick();
    end

    apply_stimulus(0, 8'h00, 2'd0);
    flush_req = 1'b0;
    out_ready = 3'b111;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
